id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding front end of the 5-stage pipelined MIPS datapath. Sits directly upstream of ALU_Module and drives its ALUCon, DataA and DataB ports.
- Captures decoded operands and control from ID each cycle.
- Resolves EX/MEM and MEM/WB data hazards by forwarding, and detects load-use hazards.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- DATA_W, 8, datapath width; must match ALU_Module.
- REG_AW, 3, register-file address width (8 registers; r0 hardwired to zero).
- ALUCON_W, 4, ALU operation code width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all ID/EX registers
- flush  in  1  replace next captured entry with bubble (branch/jump redirect)
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs_addr, id_rt_addr, id_rd_addr  in  REG_AW  source/dest register numbers (id_rd_addr already muxed rt/rd)
- id_rt_used  in  1  instruction reads rt as a source
- id_alucon  in  ALUCON_W  ALU operation
- id_alusrc  in  1  1 = DataB takes the immediate
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  control bits
- exmem_regwrite  in  1; exmem_rd  in  REG_AW; exmem_result  in  DATA_W  EX/MEM forwarding source
- memwb_regwrite  in  1; memwb_rd  in  REG_AW; memwb_result  in  DATA_W  MEM/WB forwarding source
- ALUCon  out  ALUCON_W  to ALU_Module (registered)
- DataA, DataB  out  DATA_W  to ALU_Module (combinational, after forwarding)
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1  registered control
- ex_rd_addr  out  REG_AW  registered destination
- load_use_hazard  out  1  combinational; IF/ID must hold PC and instruction when high

Behaviour:
- Reset (rst_n low, asynchronous): every register cleared to 0. ALUCon=0000, ex_valid=0, all control bits 0, ex_rd_addr=0, stored operands 0. Takes effect immediately, including mid-stall.
- Per rising edge, priority:
  - flush: load bubble.
  - else stall: hold all registers.
  - else load_use_hazard: load bubble.
  - else capture all id_* inputs; ex_valid <= id_valid.
- Bubble: ex_valid=0, ALUCon=0000, regwrite/memread/memwrite/memtoreg=0, ex_rd_addr=0. Operand registers don't care (cleared to 0).
- Forwarding, combinational on the registered rs/rt:
  - forward from EX/MEM when exmem_regwrite=1, exmem_rd!=0 and exmem_rd matches; else from MEM/WB under the same conditions; else the registered value.
  - EX/MEM has priority when both match.
  - Register 0 is never forwarded.
- Operand routing:
  - DataA = forwarded rs.
  - ex_store_data = forwarded rt.
  - DataB = id_alusrc (registered) ? registered imm : forwarded rt.
- load_use_hazard = ex_valid & ex_memread & ex_rd_addr!=0 & (ex_rd_addr==id_rs_addr | (id_rt_used & ex_rd_addr==id_rt_addr)). Evaluated against the current ID inputs.
- Latency: ID inputs appear on the registered outputs 1 cycle after the capturing edge. Forwarded values pass through with zero latency.
- Flush and stall in the same cycle: flush wins (bubble).
- Hazard during stall: no bubble is inserted, because the hold takes priority; load_use_hazard still reports high.
- No arithmetic in this block. All widths pass through unchanged; no width extension.

Test Plan:
- Reset: assert rst_n=0 mid-cycle after loading ALUCon=0010 -> ALUCon=0000 and ex_valid=0 immediately, without waiting for a clock edge.
- Plain capture: id_rs_data=8'h03, id_rt_data=8'h72, id_alucon=0000, alusrc=0, no forwarding matches -> next cycle DataA=8'h03, DataB=8'h72, ALUCon=0000.
- EX/MEM-over-MEM/WB priority: registered rs=2, exmem_rd=2 with 8'hF5, memwb_rd=2 with 8'h11, both regwrite=1 -> DataA=8'hF5. Then set exmem_regwrite=0 -> DataA=8'h11. Repeat with rs=0 -> DataA stays at the registered value.
- Immediate select: alusrc=1, imm=8'h02, rt forwarded to 8'h07 -> DataB=8'h02, ex_store_data=8'h07.
- Load-use: EX holds lw to r3 (memread=1, valid=1); ID presents rs=3 -> load_use_hazard=1, next edge ex_valid=0 with ALUCon=0000. With rt=3 and id_rt_used=0 -> load_use_hazard=0.
- Stall/flush: stall=1 for 3 cycles -> all outputs frozen. Assert flush=1 together with stall=1 -> bubble loaded on that edge.

Source files
------------

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : ID/EX stage bus. ID, EX/MEM and MEM/WB sources in; ALU
//               operands, registered control and load-use hazard out.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int DATA_W   = 8,
    parameter int REG_AW   = 3,
    parameter int ALUCON_W = 4
);
    logic                stall;
    logic                flush;
    logic                id_valid;
    logic [DATA_W-1:0]   id_rs_data;
    logic [DATA_W-1:0]   id_rt_data;
    logic [DATA_W-1:0]   id_imm;
    logic [REG_AW-1:0]   id_rs_addr;
    logic [REG_AW-1:0]   id_rt_addr;
    logic [REG_AW-1:0]   id_rd_addr;
    logic                id_rt_used;
    logic [ALUCON_W-1:0] id_alucon;
    logic                id_alusrc;
    logic                id_regwrite;
    logic                id_memread;
    logic                id_memwrite;
    logic                id_memtoreg;
    logic                exmem_regwrite;
    logic [REG_AW-1:0]   exmem_rd;
    logic [DATA_W-1:0]   exmem_result;
    logic                memwb_regwrite;
    logic [REG_AW-1:0]   memwb_rd;
    logic [DATA_W-1:0]   memwb_result;
    logic [ALUCON_W-1:0] ALUCon;
    logic [DATA_W-1:0]   DataA;
    logic [DATA_W-1:0]   DataB;
    logic [DATA_W-1:0]   ex_store_data;
    logic                ex_valid;
    logic                ex_regwrite;
    logic                ex_memread;
    logic                ex_memwrite;
    logic                ex_memtoreg;
    logic [REG_AW-1:0]   ex_rd_addr;
    logic                load_use_hazard;

    modport master (
        output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_rs_addr, id_rt_addr, id_rd_addr, id_rt_used, id_alucon,
               id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        input  ALUCon, DataA, DataB, ex_store_data, ex_valid, ex_regwrite,
               ex_memread, ex_memwrite, ex_memtoreg, ex_rd_addr, load_use_hazard
    );

    modport slave (
        input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_rs_addr, id_rt_addr, id_rd_addr, id_rt_used, id_alucon,
               id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        output ALUCon, DataA, DataB, ex_store_data, ex_valid, ex_regwrite,
               ex_memread, ex_memwrite, ex_memtoreg, ex_rd_addr, load_use_hazard
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with EX/MEM and MEM/WB operand
//               forwarding and load-use hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W   = 8,
    parameter int REG_AW   = 3,
    parameter int ALUCON_W = 4
) (
    input  wire          clk,
    input  wire          rst_n,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic                valid;
        logic [ALUCON_W-1:0] alucon;
        logic                alusrc;
        logic                regwrite;
        logic                memread;
        logic                memwrite;
        logic                memtoreg;
        logic [REG_AW-1:0]   rd_addr;
        logic [REG_AW-1:0]   rs_addr;
        logic [REG_AW-1:0]   rt_addr;
        logic [DATA_W-1:0]   rs_data;
        logic [DATA_W-1:0]   rt_data;
        logic [DATA_W-1:0]   imm;
    } ex_entry_t;

    localparam logic [REG_AW-1:0] c_reg_zero = '0;

    ex_entry_t         r_ex;
    ex_entry_t         w_captured;
    logic              w_load_use;
    logic              w_bubble;
    logic [DATA_W-1:0] w_rs_fwd;
    logic [DATA_W-1:0] w_rt_fwd;

    assign w_captured = '{
        valid:    bus.id_valid,
        alucon:   bus.id_alucon,
        alusrc:   bus.id_alusrc,
        regwrite: bus.id_regwrite,
        memread:  bus.id_memread,
        memwrite: bus.id_memwrite,
        memtoreg: bus.id_memtoreg,
        rd_addr:  bus.id_rd_addr,
        rs_addr:  bus.id_rs_addr,
        rt_addr:  bus.id_rt_addr,
        rs_data:  bus.id_rs_data,
        rt_data:  bus.id_rt_data,
        imm:      bus.id_imm
    };

    // A load in EX cannot feed the instruction in ID; compare against live ID inputs.
    assign w_load_use = r_ex.valid && r_ex.memread && (r_ex.rd_addr != c_reg_zero) &&
                        ((r_ex.rd_addr == bus.id_rs_addr) ||
                         (bus.id_rt_used && (r_ex.rd_addr == bus.id_rt_addr)));

    // Flush overrides stall; a hazard only bubbles when the stage is not held.
    assign w_bubble = bus.flush || (!bus.stall && w_load_use);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (w_bubble) begin
            r_ex <= '0;
        end else if (!bus.stall) begin
            r_ex <= w_captured;
        end
    end

    always_comb begin
        w_rs_fwd = r_ex.rs_data;
        if (bus.exmem_regwrite && (bus.exmem_rd != c_reg_zero) && (bus.exmem_rd == r_ex.rs_addr)) begin
            w_rs_fwd = bus.exmem_result;
        end else if (bus.memwb_regwrite && (bus.memwb_rd != c_reg_zero) && (bus.memwb_rd == r_ex.rs_addr)) begin
            w_rs_fwd = bus.memwb_result;
        end
    end

    always_comb begin
        w_rt_fwd = r_ex.rt_data;
        if (bus.exmem_regwrite && (bus.exmem_rd != c_reg_zero) && (bus.exmem_rd == r_ex.rt_addr)) begin
            w_rt_fwd = bus.exmem_result;
        end else if (bus.memwb_regwrite && (bus.memwb_rd != c_reg_zero) && (bus.memwb_rd == r_ex.rt_addr)) begin
            w_rt_fwd = bus.memwb_result;
        end
    end

    assign bus.DataA           = w_rs_fwd;
    assign bus.DataB           = r_ex.alusrc ? r_ex.imm : w_rt_fwd;
    assign bus.ex_store_data   = w_rt_fwd;
    assign bus.ALUCon          = r_ex.alucon;
    assign bus.ex_valid        = r_ex.valid;
    assign bus.ex_regwrite     = r_ex.regwrite;
    assign bus.ex_memread      = r_ex.memread;
    assign bus.ex_memwrite     = r_ex.memwrite;
    assign bus.ex_memtoreg     = r_ex.memtoreg;
    assign bus.ex_rd_addr      = r_ex.rd_addr;
    assign bus.load_use_hazard = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: vector table, directed
//               multi-cycle sequences and randomized run against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int CW = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW), .ALUCON_W(CW)) bus ();

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .ALUCON_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
        bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0; bus.id_rt_used = 0;
        bus.id_alucon = 0; bus.id_alusrc = 0; bus.id_regwrite = 0;
        bus.id_memread = 0; bus.id_memwrite = 0; bus.id_memtoreg = 0;
        bus.exmem_regwrite = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_regwrite = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
    endtask

    task automatic id_instr(input logic [AW-1:0] rs, input logic [DW-1:0] rsd,
                            input logic [AW-1:0] rt, input logic [DW-1:0] rtd,
                            input logic [AW-1:0] rd, input logic [CW-1:0] alu,
                            input logic src, input logic [DW-1:0] imm, input logic mr);
        bus.id_valid = 1; bus.id_rs_addr = rs; bus.id_rs_data = rsd;
        bus.id_rt_addr = rt; bus.id_rt_data = rtd; bus.id_rd_addr = rd;
        bus.id_alucon = alu; bus.id_alusrc = src; bus.id_imm = imm;
        bus.id_memread = mr; bus.id_regwrite = 1; bus.id_memtoreg = mr;
        bus.id_memwrite = 0; bus.id_rt_used = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string         name;
        logic [AW-1:0] rs;  logic [DW-1:0] rsd;
        logic [AW-1:0] rt;  logic [DW-1:0] rtd;
        logic [CW-1:0] alu; logic src; logic [DW-1:0] imm;
        logic ex_rw; logic [AW-1:0] ex_rd; logic [DW-1:0] ex_res;
        logic wb_rw; logic [AW-1:0] wb_rd; logic [DW-1:0] wb_res;
        logic [DW-1:0] exp_a; logic [DW-1:0] exp_b; logic [DW-1:0] exp_st;
    } vec_t;

    vec_t vecs[7];

    // ---------------- reference model ----------------
    typedef struct {
        logic valid; logic [CW-1:0] alu; logic src;
        logic rw; logic mr; logic mw; logic mtr;
        logic [AW-1:0] rd; logic [AW-1:0] rs; logic [AW-1:0] rt;
        logic [DW-1:0] rsd; logic [DW-1:0] rtd; logic [DW-1:0] imm;
    } model_t;

    function automatic model_t empty_entry();
        model_t m;
        m = '{valid: 0, alu: 0, src: 0, rw: 0, mr: 0, mw: 0, mtr: 0,
              rd: 0, rs: 0, rt: 0, rsd: 0, rtd: 0, imm: 0};
        return m;
    endfunction

    // Value a consumer of register `r` should see given the two in-flight writers.
    function automatic logic [DW-1:0] seen_value(input int r, input logic [DW-1:0] held,
                                                 input logic erw, input int erd, input logic [DW-1:0] eres,
                                                 input logic wrw, input int wrd, input logic [DW-1:0] wres);
        if (r == 0) return held;
        if (erw && erd == r) return eres;
        if (wrw && wrd == r) return wres;
        return held;
    endfunction

    model_t m;

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        rst_n = 0;

        vecs[0] = '{"plain",      3'd1, 8'h03, 3'd2, 8'h72, 4'h0, 0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 8'h03, 8'h72, 8'h72};
        vecs[1] = '{"exmem_prio", 3'd2, 8'h40, 3'd4, 8'h55, 4'h1, 0, 8'h00, 1, 3'd2, 8'hF5, 1, 3'd2, 8'h11, 8'hF5, 8'h55, 8'h55};
        vecs[2] = '{"memwb_only", 3'd2, 8'h40, 3'd4, 8'h55, 4'h1, 0, 8'h00, 0, 3'd2, 8'hF5, 1, 3'd2, 8'h11, 8'h11, 8'h55, 8'h55};
        vecs[3] = '{"r0_nofwd",   3'd0, 8'h33, 3'd4, 8'h55, 4'h1, 0, 8'h00, 1, 3'd0, 8'hF5, 1, 3'd0, 8'h11, 8'h33, 8'h55, 8'h55};
        vecs[4] = '{"imm_sel",    3'd1, 8'h01, 3'd5, 8'h09, 4'h2, 1, 8'h02, 1, 3'd5, 8'h07, 0, 3'd0, 8'h00, 8'h01, 8'h02, 8'h07};
        vecs[5] = '{"wb_rt",      3'd1, 8'h01, 3'd6, 8'h10, 4'h6, 0, 8'h00, 0, 3'd6, 8'h99, 1, 3'd6, 8'hAA, 8'h01, 8'hAA, 8'hAA};
        vecs[6] = '{"rd_mismatch",3'd3, 8'h21, 3'd7, 8'h44, 4'h7, 0, 8'h00, 1, 3'd4, 8'hEE, 1, 3'd5, 8'hDD, 8'h21, 8'h44, 8'h44};

        // ---- reset: asynchronous, clears a loaded entry without a clock ----
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_alucon", 32'(bus.ALUCon), 32'h0);
        chk("rst_valid", 32'(bus.ex_valid), 32'h0);
        id_instr(3'd1, 8'h10, 3'd2, 8'h20, 3'd3, 4'h2, 0, 8'h00, 0);
        tick();
        chk("load_alucon", 32'(bus.ALUCon), 32'h2);
        #2 rst_n = 0;
        #1;
        chk("async_rst_alucon", 32'(bus.ALUCon), 32'h0);
        chk("async_rst_valid", 32'(bus.ex_valid), 32'h0);
        chk("async_rst_ctrl", {bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg, 1'b0, bus.ex_rd_addr}, 32'h0);
        idle_inputs();
        @(negedge clk) rst_n = 1;

        // ---- table-driven forwarding / routing ----
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            id_instr(vecs[i].rs, vecs[i].rsd, vecs[i].rt, vecs[i].rtd, 3'd1,
                     vecs[i].alu, vecs[i].src, vecs[i].imm, 0);
            tick();
            bus.exmem_regwrite = vecs[i].ex_rw; bus.exmem_rd = vecs[i].ex_rd; bus.exmem_result = vecs[i].ex_res;
            bus.memwb_regwrite = vecs[i].wb_rw; bus.memwb_rd = vecs[i].wb_rd; bus.memwb_result = vecs[i].wb_res;
            #1;
            chk({vecs[i].name, "_A"}, 32'(bus.DataA), 32'(vecs[i].exp_a));
            chk({vecs[i].name, "_B"}, 32'(bus.DataB), 32'(vecs[i].exp_b));
            chk({vecs[i].name, "_st"}, 32'(bus.ex_store_data), 32'(vecs[i].exp_st));
            chk({vecs[i].name, "_alu"}, 32'(bus.ALUCon), 32'(vecs[i].alu));
        end

        // ---- load-use: lw r3 in EX, dependent in ID ----
        idle_inputs();
        id_instr(3'd1, 8'h00, 3'd2, 8'h00, 3'd3, 4'h2, 1, 8'h04, 1);
        tick();
        idle_inputs();
        id_instr(3'd3, 8'h00, 3'd4, 8'h00, 3'd5, 4'h2, 0, 8'h00, 0);
        #1 chk("lu_rs_hazard", 32'(bus.load_use_hazard), 32'h1);
        tick();
        chk("lu_bubble_valid", 32'(bus.ex_valid), 32'h0);
        chk("lu_bubble_alucon", 32'(bus.ALUCon), 32'h0);
        chk("lu_bubble_ctrl", {bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg, 1'b0, bus.ex_rd_addr}, 32'h0);
        id_instr(3'd1, 8'h00, 3'd2, 8'h00, 3'd3, 4'h2, 1, 8'h04, 1);
        tick();
        id_instr(3'd1, 8'h00, 3'd3, 8'h00, 3'd5, 4'h2, 0, 8'h00, 0);
        bus.id_rt_used = 0;
        #1 chk("lu_rt_unused", 32'(bus.load_use_hazard), 32'h0);
        bus.id_rt_used = 1;
        #1 chk("lu_rt_used", 32'(bus.load_use_hazard), 32'h1);

        // ---- stall holds even with a pending hazard; flush beats stall ----
        bus.stall = 1;
        for (int c = 0; c < 3; c++) begin
            bus.id_alucon = 4'(c + 9); bus.id_rd_addr = 3'(c);
            tick();
            chk("stall_valid", 32'(bus.ex_valid), 32'h1);
            chk("stall_frozen", {bus.ALUCon, bus.ex_memread, bus.ex_rd_addr, bus.DataB}, {4'h2, 1'b1, 3'd3, 8'h04});
            chk("stall_hazard", 32'(bus.load_use_hazard), 32'h1);
        end
        bus.flush = 1;
        tick();
        chk("flush_stall_valid", 32'(bus.ex_valid), 32'h0);
        chk("flush_stall_ctrl", {bus.ALUCon, bus.ex_regwrite, bus.ex_memread, bus.ex_rd_addr}, 32'h0);

        // ---- randomized run against the model ----
        idle_inputs();
        rst_n = 0;
        #2 rst_n = 1;
        m = empty_entry();
        for (int c = 0; c < 400; c++) begin
            logic haz;
            logic [DW-1:0] a_exp, rt_exp, b_exp;
            bus.stall = ($urandom_range(0, 5) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.id_valid = $urandom_range(0, 1);
            bus.id_rs_data = DW'($urandom); bus.id_rt_data = DW'($urandom); bus.id_imm = DW'($urandom);
            bus.id_rs_addr = AW'($urandom); bus.id_rt_addr = AW'($urandom); bus.id_rd_addr = AW'($urandom);
            bus.id_rt_used = $urandom_range(0, 1);
            bus.id_alucon = CW'($urandom); bus.id_alusrc = $urandom_range(0, 1);
            bus.id_regwrite = $urandom_range(0, 1); bus.id_memread = ($urandom_range(0, 2) == 0);
            bus.id_memwrite = $urandom_range(0, 1); bus.id_memtoreg = $urandom_range(0, 1);
            bus.exmem_regwrite = $urandom_range(0, 1); bus.exmem_rd = AW'($urandom); bus.exmem_result = DW'($urandom);
            bus.memwb_regwrite = $urandom_range(0, 1); bus.memwb_rd = AW'($urandom); bus.memwb_result = DW'($urandom);
            #1;
            haz = m.valid && m.mr && (m.rd != 0) &&
                  ((m.rd == bus.id_rs_addr) || (bus.id_rt_used && (m.rd == bus.id_rt_addr)));
            a_exp  = seen_value(int'(m.rs), m.rsd, bus.exmem_regwrite, int'(bus.exmem_rd), bus.exmem_result,
                                bus.memwb_regwrite, int'(bus.memwb_rd), bus.memwb_result);
            rt_exp = seen_value(int'(m.rt), m.rtd, bus.exmem_regwrite, int'(bus.exmem_rd), bus.exmem_result,
                                bus.memwb_regwrite, int'(bus.memwb_rd), bus.memwb_result);
            b_exp  = m.src ? m.imm : rt_exp;
            chk("rand_hazard", 32'(bus.load_use_hazard), 32'(haz));
            chk("rand_regs", {bus.ex_valid, bus.ALUCon, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg, bus.ex_rd_addr},
                             {m.valid, m.alu, m.rw, m.mr, m.mw, m.mtr, m.rd});
            chk("rand_data", {bus.DataA, bus.DataB, bus.ex_store_data}, {a_exp, b_exp, rt_exp});
            @(posedge clk);
            if (bus.flush || (!bus.stall && haz)) begin
                m = empty_entry();
            end else if (!bus.stall) begin
                m = '{valid: bus.id_valid, alu: bus.id_alucon, src: bus.id_alusrc,
                      rw: bus.id_regwrite, mr: bus.id_memread, mw: bus.id_memwrite, mtr: bus.id_memtoreg,
                      rd: bus.id_rd_addr, rs: bus.id_rs_addr, rt: bus.id_rt_addr,
                      rsd: bus.id_rs_data, rtd: bus.id_rt_data, imm: bus.id_imm};
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
